// File: rtl/hazard_pkg.sv
// Shared types and constants for the pipeline stall/flush scheduler.
package hazard_pkg;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    MUL   = 2'd1,
    DMISS = 2'd2
  } hz_state_t;

  localparam int REG_ADDR_WIDTH_DEF = 5;
  localparam int SRC_WIDTH_DEF      = 2;
  localparam logic [1:0] LOAD_SRC   = 2'b01;

  // Advance enables and active-low flushes for the F/D, D/E, E/M and M/W registers.
  typedef struct packed {
    logic en_f;
    logic en_d;
    logic en_e;
    logic en_m;
    logic flush_d_n;
    logic flush_e_n;
    logic flush_m_n;
    logic flush_w_n;
  } hz_ctrl_t;

  localparam hz_ctrl_t CTRL_DEFAULT = '1;

endpackage

// File: rtl/mul_stall_counter.sv
// Multiply countdown: loads MUL_LATENCY-2, decrements on request, otherwise holds.
module mul_stall_counter #(
  parameter  int MUL_LATENCY = 4,
  localparam int CNT_W       = $clog2(MUL_LATENCY)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic             dec,
  output logic             zero,
  output logic [CNT_W-1:0] cnt
);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of block evaluation order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= CNT_W'(MUL_LATENCY - 2);
    end else if (dec) begin
      cnt <= cnt - CNT_W'(1);
    end
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Central stall/flush scheduler: arbitrates dcache miss, multiply, load-use and
// icache stalls, and resolves branch-mispredict flushes that coincide with stalls.
module pipeline_hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int REG_ADDR_WIDTH = REG_ADDR_WIDTH_DEF,
  parameter int SRC_WIDTH      = SRC_WIDTH_DEF,
  parameter int MUL_LATENCY    = 4
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [REG_ADDR_WIDTH-1:0] rs1_d,
  input  logic [REG_ADDR_WIDTH-1:0] rs2_d,
  input  logic [REG_ADDR_WIDTH-1:0] rd_e,
  input  logic                      valid_e,
  input  logic                      regwrite_e,
  input  logic                      mul_sel_e,
  input  logic [SRC_WIDTH-1:0]      resultsrc_e,
  input  logic                      mispredict_e,
  input  logic                      imem_ready_f,
  input  logic                      dmem_req_m,
  input  logic                      dmem_ready_m,
  output logic                      en_f,
  output logic                      en_d,
  output logic                      en_e,
  output logic                      en_m,
  output logic                      flush_d_n,
  output logic                      flush_e_n,
  output logic                      flush_m_n,
  output logic                      flush_w_n,
  output logic                      mul_busy
);

  hz_state_t state, state_nxt;
  hz_state_t ret_state, ret_state_nxt;
  hz_state_t eff_state;
  logic      pend_flush, pend_flush_nxt;
  logic      cnt_load, cnt_dec, cnt_zero;
  hz_ctrl_t  ctrl;

  logic [$clog2(MUL_LATENCY)-1:0] cnt;

  logic miss, mul_start, load_use;

  assign miss      = dmem_req_m && !dmem_ready_m;
  assign mul_start = valid_e && mul_sel_e;
  assign load_use  = valid_e && regwrite_e && (resultsrc_e == SRC_WIDTH'(LOAD_SRC)) &&
                     (rd_e != '0) && ((rd_e == rs1_d) || (rd_e == rs2_d));

  mul_stall_counter #(
    .MUL_LATENCY(MUL_LATENCY)
  ) u_mul_cnt (
    .clk  (clk),
    .rst_n(rst_n),
    .load (cnt_load),
    .dec  (cnt_dec),
    .zero (cnt_zero),
    .cnt  (cnt)
  );

  // On the miss-release cycle the block behaves as the state it was suspended in.
  assign eff_state = (state == DMISS) ? ret_state : state;

  // NOTE: every variable written here gets a default first, so no path can
  // leave one unassigned and infer a latch.
  always_comb begin
    ctrl           = CTRL_DEFAULT;
    state_nxt      = state;
    ret_state_nxt  = ret_state;
    pend_flush_nxt = pend_flush;
    cnt_load       = 1'b0;
    cnt_dec        = 1'b0;

    if (miss) begin
      ctrl.en_f      = 1'b0;
      ctrl.en_d      = 1'b0;
      ctrl.en_e      = 1'b0;
      ctrl.en_m      = 1'b0;
      ctrl.flush_w_n = 1'b0;
      state_nxt      = DMISS;
      if (state != DMISS) ret_state_nxt = state;
    end else if (eff_state == MUL) begin
      if (cnt_zero) begin
        state_nxt = RUN;
      end else begin
        ctrl.en_f      = 1'b0;
        ctrl.en_d      = 1'b0;
        ctrl.en_e      = 1'b0;
        ctrl.flush_m_n = 1'b0;
        cnt_dec        = 1'b1;
        state_nxt      = MUL;
      end
    end else begin
      state_nxt = RUN;
      if (mul_start) begin
        ctrl.en_f      = 1'b0;
        ctrl.en_d      = 1'b0;
        ctrl.en_e      = 1'b0;
        ctrl.flush_m_n = 1'b0;
        cnt_load       = 1'b1;
        state_nxt      = MUL;
      end else if (load_use) begin
        ctrl.en_f      = 1'b0;
        ctrl.en_d      = 1'b0;
        ctrl.flush_e_n = 1'b0;
      end else if (!imem_ready_f) begin
        ctrl.en_f      = 1'b0;
        ctrl.flush_d_n = 1'b0;
      end
    end

    // A mispredict can only squash younger stages once execute actually advances.
    if ((mispredict_e || pend_flush) && ctrl.en_e) begin
      ctrl.flush_d_n = 1'b0;
      ctrl.flush_e_n = 1'b0;
      pend_flush_nxt = 1'b0;
    end else if (mispredict_e) begin
      pend_flush_nxt = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= RUN;
      ret_state  <= RUN;
      pend_flush <= 1'b0;
    end else begin
      state      <= state_nxt;
      ret_state  <= ret_state_nxt;
      pend_flush <= pend_flush_nxt;
    end
  end

  // Reset forces every pipeline register to hold and flush without waiting for a clock.
  assign en_f      = rst_n & ctrl.en_f;
  assign en_d      = rst_n & ctrl.en_d;
  assign en_e      = rst_n & ctrl.en_e;
  assign en_m      = rst_n & ctrl.en_m;
  assign flush_d_n = rst_n & ctrl.flush_d_n;
  assign flush_e_n = rst_n & ctrl.flush_e_n;
  assign flush_m_n = rst_n & ctrl.flush_m_n;
  assign flush_w_n = rst_n & ctrl.flush_w_n;
  assign mul_busy  = (state == MUL);

endmodule
